// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Buffered UART transmitter: an 8-deep (2**ADDR_W) byte FIFO feeding a frame
// serializer with its own baud timer. Frame: start(0), 8 data bits LSB first,
// optional even/odd parity, 1 or 2 stop bits(1). The frame configuration is
// latched when a byte is popped, so it stays fixed for the whole frame.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   wr_en      push request for wr_data (accepted when !full)
//   wr_data    byte to queue
//   parity_en  1 = append a parity bit after the data
//   parity_odd parity sense: 0 = even, 1 = odd
//   two_stop   1 = two stop bits, 0 = one
//   full       FIFO holds 2**ADDR_W entries
//   empty      FIFO holds 0 entries
//   level      FIFO occupancy, 0..2**ADDR_W
//   ovf        one-clk pulse after a push was rejected because the FIFO was full
//   busy       serializer active or FIFO not empty
//   tx_out     serial line, idle high, driven from a flop
//   state_dbg  current serializer state (debug observation)
//
// Handshake: wr_en is sampled every rising edge; a push is accepted on that edge
// exactly when full was low before the edge. There is no back-pressure other
// than full; a rejected push is reported via ovf and the byte is lost.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              ovf,
  output logic              busy,
  output logic              tx_out,
  output logic [2:0]        state_dbg
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   T_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(1 << ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t state, state_nx;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]        mem [1 << ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push, pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign level = count;
  assign push  = wr_en && !full;
  // The serializer only takes a byte while idle.
  assign pop   = (state == S_IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
      // Uses full from before the edge: a same-cycle pop cannot rescue it.
      ovf <= wr_en && full;
    end
  end

  // ---------------------------------------------------------- serializer
  logic [TW-1:0] timer;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          stop_cnt;
  logic          par_bit;
  logic          par_en_l;
  logic          two_stop_l;
  logic          bit_done;
  logic          bit_start;
  logic          tx_nx;

  assign bit_done  = (timer == '0);
  assign busy      = (state != S_IDLE) || !empty;
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!empty) state_nx = S_START;
      S_START:  if (bit_done) state_nx = S_DATA;
      S_DATA:   if (bit_done && (bit_cnt == 3'd7))
                  state_nx = par_en_l ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) state_nx = S_STOP;
      S_STOP:   if (bit_done && (!two_stop_l || stop_cnt)) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output logic: next line level and "a new bit period starts on this edge".
  // The line level is registered below so tx_out never glitches.
  always_comb begin
    tx_nx     = tx_out;
    bit_start = 1'b0;
    if (state == S_IDLE) begin
      tx_nx = 1'b1;
      if (!empty) begin
        tx_nx     = 1'b0;
        bit_start = 1'b1;
      end
    end else if (bit_done) begin
      bit_start = (state_nx != S_IDLE);
      case (state_nx)
        S_DATA:   tx_nx = shift_reg[0];
        S_PARITY: tx_nx = par_bit;
        default:  tx_nx = 1'b1;
      endcase
    end
  end

  // Datapath: line flop, bit timer, shift register, counters, frame config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_out     <= 1'b1;
      timer      <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      par_bit    <= 1'b0;
      par_en_l   <= 1'b0;
      two_stop_l <= 1'b0;
    end else begin
      tx_out <= tx_nx;

      if (bit_start)       timer <= T_LOAD;
      else if (!bit_done)  timer <= timer - TW'(1);

      if (pop) begin
        shift_reg  <= mem[rd_ptr];
        par_bit    <= (^mem[rd_ptr]) ^ parity_odd;
        par_en_l   <= parity_en;
        two_stop_l <= two_stop;
      end else if ((state_nx == S_DATA) && bit_done) begin
        // The bit just placed on the line leaves; the next one moves to [0].
        shift_reg <= shift_reg >> 1;
      end

      if ((state == S_START) && bit_done)     bit_cnt <= '0;
      else if ((state == S_DATA) && bit_done) bit_cnt <= bit_cnt + 3'd1;

      if (state != S_STOP) stop_cnt <= 1'b0;
      else if (bit_done)   stop_cnt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo with CLKS_PER_BIT=16. A line monitor decodes
// frames from tx_out sample by sample and compares each decoded byte against
// the scoreboard queue filled when bytes are pushed.
module tb_uart_tx_fifo;
  localparam int CPB = 16;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          two_stop = 1'b0;
  logic          full, empty, ovf, busy, tx_out;
  logic [AW:0]   level;
  logic [2:0]    state_dbg;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  // ------------------------------------------------ clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .full(full), .empty(empty), .level(level), .ovf(ovf), .busy(busy),
    .tx_out(tx_out), .state_dbg(state_dbg)
  );

  // ------------------------------------------------------ driver tasks
  task automatic set_cfg(input logic pen, input logic podd, input logic ts);
    parity_en  = pen;
    parity_odd = podd;
    two_stop   = ts;
  endtask

  // Called at a negedge; returns at the negedge after the capturing edge.
  task automatic push_one(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // One bit period starting at the current sample; returns positioned on the
  // first sample of the following period.
  task automatic rx_period(output logic v, output logic stable);
    v      = tx_out;
    stable = 1'b1;
    for (int i = 1; i < CPB; i++) begin
      @(negedge clk);
      if (tx_out !== v) stable = 1'b0;
    end
    @(negedge clk);
  endtask

  // ------------------------------------------- line monitor/scoreboard
  task automatic rx_frame(input logic pen, input logic podd, input logic ts,
                          output int pre);
    logic v, st, bad;
    logic [7:0] got, exp;
    int nstop;
    pre = 0;
    while (tx_out === 1'b1 && pre < 4000) begin
      pre++;
      @(negedge clk);
    end
    checks++;
    if (tx_out !== 1'b0) begin
      errors++;
      $display("FAIL rx_start: tx_out=%b after %0d clks, required 0", tx_out, pre);
      return;
    end
    rx_period(v, st);
    checks++;
    if (!st) begin
      errors++;
      $display("FAIL rx_start_width: start bit not held %0d clks", CPB);
    end
    bad = 1'b0;
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rx_period(v, st);
      got[i] = v;
      if (!st) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rx_data_width: a data bit was not held %0d clks", CPB);
    end
    exp = 8'h00;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL rx_unexpected: got byte 0x%02h, required no frame", got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL rx_data: got 0x%02h, required 0x%02h", got, exp);
      end
    end
    if (pen) begin
      rx_period(v, st);
      checks++;
      if (v !== ((^exp) ^ podd) || !st) begin
        errors++;
        $display("FAIL rx_parity: got %b stable=%b, required %b stable=1",
                 v, st, (^exp) ^ podd);
      end
    end
    nstop = ts ? 2 : 1;
    bad = 1'b0;
    for (int i = 0; i < nstop; i++) begin
      rx_period(v, st);
      if (v !== 1'b1 || !st) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rx_stop: stop level not high for %0d clks", nstop * CPB);
    end
  endtask

  // Line must stay idle and busy low for n clks.
  task automatic expect_quiet(input int n, input string name);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (tx_out !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: line/busy activity seen, required tx_out=1 busy=0", name);
    end
  endtask

  // ------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx_out); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL post_reset_tx: got %b, required 1", tx_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b, required 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b, required 1", empty); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d, required 0", level); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
  endtask

  task automatic test_8n1();
    int pre;
    set_cfg(1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'hAB);
    push_one(8'hAB);
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL lat_level: got %0d, required 1", level); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL lat_empty: got %b, required 0", empty); end
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL lat_tx_early: got %b, required 1", tx_out); end
    @(negedge clk);
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL pop_level: got %0d, required 0", level); end
    checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL lat_start: got %b, required 0", tx_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_frame: got %b, required 1", busy); end
    rx_frame(1'b0, 1'b0, 1'b0, pre);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end_8n1: got %b, required 0", busy); end
  endtask

  task automatic test_parity();
    int pre;
    // 8E1 0xAB with the inputs changed mid-frame; the frame must keep 8E1.
    set_cfg(1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'hAB);
    push_one(8'hAB);
    fork
      rx_frame(1'b1, 1'b0, 1'b0, pre);
      begin
        repeat (30) @(negedge clk);
        set_cfg(1'b0, 1'b1, 1'b1);
      end
    join
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end_8e1: got %b, required 0", busy); end
    set_cfg(1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'hAB);
    push_one(8'hAB);
    rx_frame(1'b1, 1'b1, 1'b0, pre);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end_8o1: got %b, required 0", busy); end
    set_cfg(1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h00);
    push_one(8'h00);
    rx_frame(1'b1, 1'b0, 1'b0, pre);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end_8e1_zero: got %b, required 0", busy); end
  endtask

  task automatic test_two_stop();
    int pre;
    set_cfg(1'b0, 1'b0, 1'b1);
    exp_q.push_back(8'h00);
    push_one(8'h00);
    rx_frame(1'b0, 1'b0, 1'b1, pre);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end_8n2: got %b, required 0", busy); end
    set_cfg(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    int pre;
    int exp_lvl;
    set_cfg(1'b0, 1'b0, 1'b0);
    fork
      begin
        for (int i = 1; i <= 9; i++) begin
          wr_en   = 1'b1;
          wr_data = 8'(i);
          exp_q.push_back(8'(i));
          @(negedge clk);
          exp_lvl = (i == 1) ? 1 : i - 1;
          checks++;
          if (level !== 4'(exp_lvl)) begin
            errors++;
            $display("FAIL fill_level[%0d]: got %0d, required %0d", i, level, exp_lvl);
          end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b, required 1", full); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fill_ovf: got %b, required 0", ovf); end
        wr_data = 8'h0A;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b, required 1", ovf); end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d, required 8", level); end
        @(negedge clk);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_width: got %b, required 0", ovf); end
      end
      begin
        for (int f = 0; f < 9; f++) begin
          rx_frame(1'b0, 1'b0, 1'b0, pre);
          if (f > 0) begin
            checks++;
            if (pre !== 1) begin
              errors++;
              $display("FAIL frame_gap[%0d]: idle clks after stop=%0d, required 1", f, pre);
            end
          end
        end
      end
    join
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_leftover: %0d bytes not seen, required 0", exp_q.size()); end
    expect_quiet(200, "ovf_dropped_byte");
  endtask

  task automatic test_back_to_back();
    int pre;
    set_cfg(1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h46);
    exp_q.push_back(8'hAB);
    wr_en = 1'b1;
    wr_data = 8'h46;
    @(negedge clk);
    wr_data = 8'hAB;
    @(negedge clk);
    wr_en = 1'b0;
    rx_frame(1'b0, 1'b0, 1'b0, pre);
    rx_frame(1'b0, 1'b0, 1'b0, pre);
    checks++; if (pre !== 1) begin errors++; $display("FAIL b2b_gap: got %0d, required 1", pre); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b, required 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    set_cfg(1'b0, 1'b0, 1'b0);
    wr_en = 1'b1;
    wr_data = 8'h00;
    repeat (4) @(negedge clk);
    wr_en = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL mid_data_tx: got %b, required 0", tx_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL async_rst_tx: got %b, required 1", tx_out); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL async_rst_level: got %0d, required 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL async_rst_empty: got %b, required 1", empty); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_quiet(300, "post_reset_quiet");
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_two_stop();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
